data_splitter: RTL and testbench
================================

Name: data_splitter

Overview:
- Transmit-side counterpart of the two-channel data aligner.
- Accepts one aligned word pair per handshake and releases each half onto its own independent output channel.
- Each output channel has its own valid/ready handshake, so the two channels drain at unrelated rates.
- Each channel is buffered by a dedicated FIFO. Per-channel full statuses and a sticky drop flag are reported upstream.

Parameters:
- WIDTH_FIFO, 8: width of each data word.
- DEPTH, 8: entries per channel FIFO; power of two, ≥2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- data_1st_i  in  WIDTH_FIFO  first half of the aligned pair.
- data_2d_i  in  WIDTH_FIFO  second half of the aligned pair.
- vld_i  in  1  pair valid.
- rdy_o  out  1  pair accepted when vld_i & rdy_o.
- data_1st_o  out  WIDTH_FIFO  channel 1 head word.
- vld_1st_o  out  1  channel 1 valid.
- rdy_1st_i  in  1  channel 1 consumer ready.
- data_2d_o  out  WIDTH_FIFO  channel 2 head word.
- vld_2d_o  out  1  channel 2 valid.
- rdy_2d_i  in  1  channel 2 consumer ready.
- statuses_o  out  2  [0] = ch1 FIFO full, [1] = ch2 FIFO full.
- drop_o  out  1  sticky: a pair was offered while rdy_o was low.

Behaviour:
- Reset: one cycle of rst=1, sampled on clk, clears all state.
  - Resulting values: pointers=0, counts=0, vld_1st_o=0, vld_2d_o=0, data_*_o=0, statuses_o=2'b00, drop_o=0.
  - rdy_o=1 in the first cycle after reset.
  - Reset mid-operation discards all buffered words; no partial pair survives.
- Per-channel FIFO:
  - Circular buffer of DEPTH entries.
  - Read/write pointers of $clog2(DEPTH) bits; they wrap from DEPTH-1 to 0.
  - Occupancy counter of $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Input handshake:
  - rdy_o = !full_1st & !full_2d, derived combinationally from registered counts.
  - On vld_i & rdy_o, both halves are written in the same cycle, one to each FIFO; a pair is never split across cycles.
  - rdy_o is not raised by a same-cycle output pop. A full FIFO refuses the write even if its consumer reads that cycle.
- Drop:
  - vld_i & !rdy_o sets drop_o=1; the pair is discarded.
  - drop_o stays 1 until rst. vld_i is not required to be held by the source.
- Output channels (identical, fully independent):
  - vld_x_o = (count_x != 0).
  - data_x_o = memory at the read pointer; stable while vld_x_o & !rdy_x_i.
  - A pop occurs on vld_x_o & rdy_x_i.
  - rdy_x_i while vld_x_o=0 has no effect; there is no underflow and the counter never goes negative.
- Latency: a pair accepted at edge N gives vld_1st_o=vld_2d_o=1 after edge N, when both FIFOs were empty. There is no combinational path from input to output.
- Simultaneous push and pop on a non-empty, non-full channel: count unchanged, both pointers advance.
- Ordering: each channel outputs words strictly in acceptance order.
  - Channel 1 word k and channel 2 word k always originate from the same input pair.
- statuses_o[x] = (count_x == DEPTH), registered-count based; it updates in the same cycle as the count.
- Throughput: 1 pair per cycle while both consumers hold ready=1.

Test Plan:
1. Reset, then idle → rdy_o=1, vld_1st_o=0, vld_2d_o=0, statuses_o=00, drop_o=0.
2. Push pair (0x11,0x22) with rdy_1st_i=rdy_2d_i=1:
   - the next cycle shows data_1st_o=0x11, data_2d_o=0x22, both valid;
   - one cycle later both valid flags are 0.
3. Ch1 streaming, ch2 stalled:
   - stimulus: hold rdy_2d_i=0, rdy_1st_i=1, push pairs (i, 0x80+i) for i=0..9;
   - after 8 accepts statuses_o=10 and rdy_o=0;
   - pairs 8 and 9 are dropped and drop_o=1;
   - ch1 emitted 0..7.
4. Release after stall: continue from scenario 3 with rdy_2d_i=1 → ch2 emits 0x80..0x87 in order; statuses_o returns to 00; drop_o stays 1.
5. Wrap-around: alternating push and pop over 20 pairs with random per-channel ready → both channels output words in order. A scoreboard matches pair k across channels, and no word is lost or duplicated across pointer wrap.
6. Mid-operation reset: with 5 pairs buffered, assert rst for 1 cycle → all valids are 0 the next cycle; the next pushed pair (0xAA,0xBB) is the first word out on each channel.

Source files
------------

// File: rtl/data_splitter.sv
// rtl/data_splitter.sv - splits an aligned word pair onto two independently drained FIFO channels
// Both halves are written together; each channel pops on its own valid/ready handshake.
module data_splitter #(
  parameter int WIDTH_FIFO = 8,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH_FIFO-1:0] data_1st_i,
  input  logic [WIDTH_FIFO-1:0] data_2d_i,
  input  logic                  vld_i,
  output logic                  rdy_o,
  output logic [WIDTH_FIFO-1:0] data_1st_o,
  output logic                  vld_1st_o,
  input  logic                  rdy_1st_i,
  output logic [WIDTH_FIFO-1:0] data_2d_o,
  output logic                  vld_2d_o,
  input  logic                  rdy_2d_i,
  output logic [1:0]            statuses_o,
  output logic                  drop_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH_FIFO-1:0] mem_1st [DEPTH];
  logic [WIDTH_FIFO-1:0] mem_2d  [DEPTH];
  logic [PTR_W-1:0]      wptr_1st, rptr_1st, wptr_2d, rptr_2d;
  logic [CNT_W-1:0]      count_1st, count_2d;
  logic                  full_1st, full_2d;
  logic                  push, pop_1st, pop_2d;
  logic                  drop;

  // Readiness comes from registered counts only, so a same-cycle pop never frees a slot.
  assign full_1st   = (count_1st == FULL_CNT);
  assign full_2d    = (count_2d == FULL_CNT);
  assign rdy_o      = !full_1st && !full_2d;
  assign push       = vld_i && rdy_o;
  assign statuses_o = {full_2d, full_1st};
  assign drop_o     = drop;

  assign vld_1st_o  = (count_1st != '0);
  assign vld_2d_o   = (count_2d != '0);
  assign pop_1st    = vld_1st_o && rdy_1st_i;
  assign pop_2d     = vld_2d_o && rdy_2d_i;

  // Gating with valid keeps stale memory contents off the outputs after reset.
  assign data_1st_o = vld_1st_o ? mem_1st[rptr_1st] : '0;
  assign data_2d_o  = vld_2d_o ? mem_2d[rptr_2d] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_1st[wptr_1st] <= data_1st_i;
      mem_2d[wptr_2d]   <= data_2d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_1st  <= '0;
      rptr_1st  <= '0;
      count_1st <= '0;
    end else begin
      if (push) wptr_1st <= wptr_1st + PTR_ONE;
      if (pop_1st) rptr_1st <= rptr_1st + PTR_ONE;
      case ({push, pop_1st})
        2'b10:   count_1st <= count_1st + CNT_ONE;
        2'b01:   count_1st <= count_1st - CNT_ONE;
        default: count_1st <= count_1st;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_2d  <= '0;
      rptr_2d  <= '0;
      count_2d <= '0;
    end else begin
      if (push) wptr_2d <= wptr_2d + PTR_ONE;
      if (pop_2d) rptr_2d <= rptr_2d + PTR_ONE;
      case ({push, pop_2d})
        2'b10:   count_2d <= count_2d + CNT_ONE;
        2'b01:   count_2d <= count_2d - CNT_ONE;
        default: count_2d <= count_2d;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop <= 1'b0;
    end else if (vld_i && !rdy_o) begin
      drop <= 1'b1;
    end
  end
endmodule

// File: tb/tb_data_splitter.sv
// tb/tb_data_splitter.sv - self-checking bench for data_splitter
// Queue-based reference model of the two channels, checked every cycle before the clock edge.
module tb_data_splitter;
  localparam int W     = 8;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_1st_i, data_2d_i;
  logic         vld_i;
  logic         rdy_o;
  logic [W-1:0] data_1st_o, data_2d_o;
  logic         vld_1st_o, vld_2d_o;
  logic         rdy_1st_i, rdy_2d_i;
  logic [1:0]   statuses_o;
  logic         drop_o;

  data_splitter #(.WIDTH_FIFO(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .data_1st_i(data_1st_i), .data_2d_i(data_2d_i), .vld_i(vld_i), .rdy_o(rdy_o),
    .data_1st_o(data_1st_o), .vld_1st_o(vld_1st_o), .rdy_1st_i(rdy_1st_i),
    .data_2d_o(data_2d_o), .vld_2d_o(vld_2d_o), .rdy_2d_i(rdy_2d_i),
    .statuses_o(statuses_o), .drop_o(drop_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] q1[$], q2[$];
  bit           m_drop;
  logic [W-1:0] acc1[$], acc2[$];
  logic [W-1:0] log1[$], log2[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q1.delete(); q2.delete();
    m_drop = 1'b0;
  endtask

  task automatic clear_logs();
    acc1.delete(); acc2.delete();
    log1.delete(); log2.delete();
  endtask

  // Compare outputs with the model, then advance the model across one clock edge.
  task automatic step();
    bit e_rdy, e_v1, e_v2, acc, p1, p2, dset, do_rst;
    logic [W-1:0] d1, d2;
    e_rdy = (q1.size() < DEPTH) && (q2.size() < DEPTH);
    e_v1  = (q1.size() != 0);
    e_v2  = (q2.size() != 0);
    check("rdy_o", rdy_o, e_rdy);
    check("vld_1st_o", vld_1st_o, e_v1);
    check("vld_2d_o", vld_2d_o, e_v2);
    check("statuses_o", statuses_o, {q2.size() == DEPTH, q1.size() == DEPTH});
    check("drop_o", drop_o, m_drop);
    if (e_v1) check("data_1st_o", data_1st_o, q1[0]);
    if (e_v2) check("data_2d_o", data_2d_o, q2[0]);
    do_rst = rst;
    acc  = vld_i && e_rdy;
    dset = vld_i && !e_rdy;
    p1   = e_v1 && rdy_1st_i;
    p2   = e_v2 && rdy_2d_i;
    d1   = data_1st_i;
    d2   = data_2d_i;
    if (!do_rst && vld_1st_o && rdy_1st_i) log1.push_back(data_1st_o);
    if (!do_rst && vld_2d_o && rdy_2d_i) log2.push_back(data_2d_o);
    @(posedge clk);
    #1;
    if (do_rst) begin
      model_clear();
    end else begin
      if (p1) void'(q1.pop_front());
      if (p2) void'(q2.pop_front());
      if (acc) begin
        q1.push_back(d1); q2.push_back(d2);
        acc1.push_back(d1); acc2.push_back(d2);
      end
      if (dset) m_drop = 1'b1;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; vld_i = 1'b0; data_1st_i = '0; data_2d_i = '0;
    rdy_1st_i = 1'b0; rdy_2d_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    clear_logs();

    // 1: reset state
    check("s1_rdy", rdy_o, 1'b1);
    check("s1_vld_1st", vld_1st_o, 1'b0);
    check("s1_vld_2d", vld_2d_o, 1'b0);
    check("s1_statuses", statuses_o, 2'b00);
    check("s1_drop", drop_o, 1'b0);
    check("s1_data_1st", data_1st_o, 8'h00);
    check("s1_data_2d", data_2d_o, 8'h00);
    step();

    // 2: single pair, one cycle latency
    rdy_1st_i = 1'b1; rdy_2d_i = 1'b1;
    vld_i = 1'b1; data_1st_i = 8'h11; data_2d_i = 8'h22;
    step();
    vld_i = 1'b0;
    check("s2_vld_1st", vld_1st_o, 1'b1);
    check("s2_vld_2d", vld_2d_o, 1'b1);
    check("s2_data_1st", data_1st_o, 8'h11);
    check("s2_data_2d", data_2d_o, 8'h22);
    step();
    check("s2_empty_1st", vld_1st_o, 1'b0);
    check("s2_empty_2d", vld_2d_o, 1'b0);

    // 3: ch2 stalled until full, overflow pairs dropped
    clear_logs();
    rdy_1st_i = 1'b1; rdy_2d_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 8) begin
        check("s3_statuses", statuses_o, 2'b10);
        check("s3_rdy", rdy_o, 1'b0);
      end
      vld_i = 1'b1; data_1st_i = W'(i); data_2d_i = W'(8'h80 + i);
      step();
    end
    vld_i = 1'b0;
    check("s3_drop", drop_o, 1'b1);
    check("s3_ch1_count", log1.size(), 8);
    for (int k = 0; k < 8 && k < log1.size(); k++) check("s3_ch1_word", log1[k], k);

    // 4: release ch2
    rdy_2d_i = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("s4_ch2_count", log2.size(), 8);
    for (int k = 0; k < 8 && k < log2.size(); k++) check("s4_ch2_word", log2[k], 8'h80 + k);
    check("s4_statuses", statuses_o, 2'b00);
    check("s4_drop", drop_o, 1'b1);

    // 5: randomized traffic across pointer wrap
    clear_logs();
    n = 0;
    for (int c = 0; c < 400 && n < 20; c++) begin
      vld_i = (c % 2 == 0);
      data_1st_i = W'($urandom); data_2d_i = W'($urandom);
      rdy_1st_i = W'($urandom_range(0, 1)) != 0;
      rdy_2d_i  = W'($urandom_range(0, 1)) != 0;
      if (vld_i && rdy_o) n++;
      step();
    end
    vld_i = 1'b0; rdy_1st_i = 1'b1; rdy_2d_i = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) step();
    check("s5_accepted", n, 20);
    check("s5_ch1_count", log1.size(), acc1.size());
    check("s5_ch2_count", log2.size(), acc2.size());
    for (int k = 0; k < acc1.size() && k < log1.size() && k < log2.size(); k++) begin
      check("s5_pair_ch1", log1[k], acc1[k]);
      check("s5_pair_ch2", log2[k], acc2[k]);
    end

    // 6: reset with words buffered
    clear_logs();
    rdy_1st_i = 1'b0; rdy_2d_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vld_i = 1'b1; data_1st_i = W'(8'h40 + i); data_2d_i = W'(8'h50 + i);
      step();
    end
    vld_i = 1'b0;
    check("s6_buffered", vld_1st_o, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("s6_vld_1st", vld_1st_o, 1'b0);
    check("s6_vld_2d", vld_2d_o, 1'b0);
    check("s6_drop", drop_o, 1'b0);
    vld_i = 1'b1; data_1st_i = 8'hAA; data_2d_i = 8'hBB;
    step();
    vld_i = 1'b0;
    check("s6_data_1st", data_1st_o, 8'hAA);
    check("s6_data_2d", data_2d_o, 8'hBB);
    rdy_1st_i = 1'b1; rdy_2d_i = 1'b1;
    step();
    check("s6_first_1st", log1.size() > 0 ? log1[0] : 8'hxx, 8'hAA);
    check("s6_first_2d", log2.size() > 0 ? log2[0] : 8'hxx, 8'hBB);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
